// File: rtl/bancoreg_sequencer.sv
// Self-test initiator for the Bancoreg register bank: writes a descending
// pattern into every register, reads pairs back through both read ports
// and reports pass/fail, first failing address and mismatch count.
module bancoreg_sequencer #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 4,
  parameter int SEED     = 15,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] datOutRa,
  input  logic [DATA_W-1:0] datOutRb,
  output logic [ADDR_W-1:0] addrRa,
  output logic [ADDR_W-1:0] addrRb,
  output logic [ADDR_W-1:0] addrW,
  output logic [DATA_W-1:0] datW,
  output logic              RegWrite,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   mism_cnt
);
  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(N-1);
  localparam logic [ADDR_W-1:0] HALF_LAST = ADDR_W'(N/2-1);
  localparam logic [DATA_W-1:0] SEED_V    = DATA_W'(SEED);
  // RD_WAIT lasts READ_LAT-1 cycles; counter runs 0..READ_LAT-2
  localparam logic [1:0]        WAIT_LAST = 2'(READ_LAT > 1 ? READ_LAT-2 : 0);
  localparam logic [ADDR_W+1:0] CNT_MAX   = (ADDR_W+2)'(N);

  typedef enum logic [2:0] {IDLE, WRITE, RD_SET, RD_WAIT, RD_CHK, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;     // write index i, then pair index p
  logic [1:0]        wcnt_q, wcnt_d;
  logic              armed_q, armed_d; // start must drop before it can relaunch

  logic [ADDR_W-1:0] ra_d, rb_d, aw_d, ea_d;
  logic [DATA_W-1:0] dw_d;
  logic              we_d, busy_d, done_d, err_d;
  logic [ADDR_W:0]   cnt_d;
  logic              launch, check_now, miss_a, miss_b;
  logic [ADDR_W+1:0] cnt_sum;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return SEED_V - DATA_W'(a);
  endfunction

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    armed_d = armed_q | ~start;
    ra_d    = addrRa;
    rb_d    = addrRb;
    aw_d    = addrW;
    dw_d    = datW;
    we_d    = 1'b0;
    busy_d  = busy;
    done_d  = done;
    err_d   = error;
    ea_d    = err_addr;
    cnt_d   = mism_cnt;
    miss_a  = 1'b0;
    miss_b  = 1'b0;
    cnt_sum = '0;
    launch    = start && armed_q && (state_q == IDLE || state_q == DONE);
    check_now = (state_q == RD_CHK) || (state_q == RD_SET && READ_LAT == 0);

    case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          state_d = WRITE;
          armed_d = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          ea_d    = '0;
          cnt_d   = '0;
          idx_d   = '0;
          we_d    = 1'b1;
          aw_d    = '0;
          dw_d    = pattern('0);
        end
      end
      WRITE: begin
        if (idx_q == LAST) begin
          state_d = RD_SET;
          idx_d   = '0;
          ra_d    = '0;
          rb_d    = LAST;
        end else begin
          idx_d = idx_q + 1'b1;
          we_d  = 1'b1;
          aw_d  = idx_q + 1'b1;
          dw_d  = pattern(idx_q + 1'b1);
        end
      end
      RD_SET: begin
        if (READ_LAT > 1) begin
          state_d = RD_WAIT;
          wcnt_d  = '0;
        end else if (READ_LAT == 1) begin
          state_d = RD_CHK;
        end
      end
      RD_WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = RD_CHK;
        else                     wcnt_d  = wcnt_q + 1'b1;
      end
      RD_CHK: ;
      default: state_d = IDLE;
    endcase

    // Pair check: shared by RD_CHK and the zero-latency RD_SET case
    if (check_now) begin
      miss_a  = datOutRa != pattern(addrRa);
      miss_b  = datOutRb != pattern(addrRb);
      cnt_sum = {1'b0, mism_cnt} + (ADDR_W+2)'(miss_a) + (ADDR_W+2)'(miss_b);
      cnt_d   = (cnt_sum > CNT_MAX) ? CNT_MAX[ADDR_W:0] : cnt_sum[ADDR_W:0];
      if (!error && (miss_a || miss_b)) begin
        err_d = 1'b1;
        ea_d  = miss_a ? addrRa : addrRb;  // port A wins a double first failure
      end
      if (idx_q == HALF_LAST) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = RD_SET;
        idx_d   = idx_q + 1'b1;
        ra_d    = idx_q + 1'b1;
        rb_d    = LAST - idx_q - 1'b1;
      end
    end
  end

  // State and output registers; async reset also kills RegWrite at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wcnt_q   <= '0;
      armed_q  <= 1'b1;
      addrRa   <= '0;
      addrRb   <= '0;
      addrW    <= '0;
      datW     <= '0;
      RegWrite <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
      mism_cnt <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      armed_q  <= armed_d;
      addrRa   <= ra_d;
      addrRb   <= rb_d;
      addrW    <= aw_d;
      datW     <= dw_d;
      RegWrite <= we_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= err_d;
      err_addr <= ea_d;
      mism_cnt <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bancoreg_sequencer.sv
// Bench for bancoreg_sequencer: two instances (READ_LAT=1/SEED=15 and
// READ_LAT=2/SEED=3) each beside a behavioural bank with fault injection.
module tb_bancoreg_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic [2:0] addr_ra [2], addr_rb [2], addr_w [2], err_addr [2];
  logic [3:0] dat_w [2], dout_a [2], dout_b [2], mism [2];
  logic reg_write [2], busy [2], done [2], error [2];

  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  bancoreg_sequencer #(.ADDR_W(3), .DATA_W(4), .SEED(15), .READ_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .datOutRa(dout_a[0]), .datOutRb(dout_b[0]),
    .addrRa(addr_ra[0]), .addrRb(addr_rb[0]), .addrW(addr_w[0]), .datW(dat_w[0]),
    .RegWrite(reg_write[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
    .err_addr(err_addr[0]), .mism_cnt(mism[0]));

  bancoreg_sequencer #(.ADDR_W(3), .DATA_W(4), .SEED(3), .READ_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .datOutRa(dout_a[1]), .datOutRb(dout_b[1]),
    .addrRa(addr_ra[1]), .addrRb(addr_rb[1]), .addrW(addr_w[1]), .datW(dat_w[1]),
    .RegWrite(reg_write[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
    .err_addr(err_addr[1]), .mism_cnt(mism[1]));

  // Bank model with fault injection: stuck registers, disconnected write enable
  logic [3:0] mem [2][8];
  bit         stuck_en [8];
  logic [3:0] stuck_val [8];
  bit         wdis, clr;
  logic [3:0] a1_p, b1_p;

  function automatic logic [3:0] rd(input int d, input logic [2:0] a);
    return stuck_en[a] ? stuck_val[a] : mem[d][a];
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      for (int d = 0; d < 2; d++) for (int a = 0; a < 8; a++) mem[d][a] <= '0;
    end else begin
      for (int d = 0; d < 2; d++) if (reg_write[d] && !wdis) mem[d][addr_w[d]] <= dat_w[d];
    end
    dout_a[0] <= rd(0, addr_ra[0]);
    dout_b[0] <= rd(0, addr_rb[0]);
    a1_p      <= rd(1, addr_ra[1]);
    b1_p      <= rd(1, addr_rb[1]);
    dout_a[1] <= a1_p;
    dout_b[1] <= b1_p;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int d, input int a);
    int s;
    s = (d != 0) ? 3 : 15;
    return 4'((s - a) & 15);
  endfunction

  // Reference: walk the pairs in order, A before B, against the bank's contents
  task automatic model(input int d, output bit e, output int ea, output int cnt);
    int a;
    logic [3:0] got;
    e = 0; ea = 0; cnt = 0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 2; k++) begin
        a   = (k != 0) ? 7 - p : p;
        got = stuck_en[a] ? stuck_val[a] : (wdis ? 4'd0 : pat(d, a));
        if (got != pat(d, a)) begin
          cnt++;
          if (!e) begin e = 1; ea = a; end
        end
      end
    end
  endtask

  task automatic no_faults();
    for (int i = 0; i < 8; i++) begin stuck_en[i] = 0; stuck_val[i] = '0; end
    wdis = 0;
  endtask

  task automatic run(input int d, input bit hold, input bit poke);
    bit e; int ea, cnt, c, w, explen;
    model(d, e, ea, cnt);
    explen = 8 + 4 * (1 + ((d != 0) ? 2 : 1)) + 1;
    clr = 1; @(negedge clk); clr = 0;
    start[d] = 1;
    @(negedge clk);
    if (!hold) start[d] = 0;
    c = 1; w = 0;
    chk("st_busy", busy[d], 1);
    chk("st_done", done[d], 0);
    chk("st_err", error[d], 0);
    chk("st_cnt", mism[d], 0);
    while (!done[d] && c < 200) begin
      if (reg_write[d]) begin
        chk("wr_addr", addr_w[d], w);
        chk("wr_data", dat_w[d], pat(d, w));
        w++;
      end
      if (poke && !hold && c == 5) start[d] = 1;
      if (poke && !hold && c == 6) start[d] = 0;
      @(negedge clk);
      c++;
    end
    chk("run_len", c, explen);
    chk("wr_count", w, 8);
    chk("end_busy", busy[d], 0);
    chk("end_we", reg_write[d], 0);
    chk("error", error[d], e);
    chk("err_addr", err_addr[d], ea);
    chk("mism_cnt", mism[d], cnt);
    if (hold) begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("hold_done", done[d], 1);
        chk("hold_busy", busy[d], 0);
      end
      start[d] = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1; start[0] = 0; start[1] = 0; clr = 0;
    no_faults();
    repeat (2) @(negedge clk);
    chk("rst_we", reg_write[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_err", error[0], 0);
    chk("rst_ea", err_addr[0], 0);
    chk("rst_cnt", mism[0], 0);
    chk("rst_aw", addr_w[0], 0);
    chk("rst_dw", dat_w[0], 0);
    chk("rst_ra", addr_ra[0], 0);
    chk("rst_rb", addr_rb[0], 0);
    rst = 0;
    @(negedge clk);

    run(0, 0, 0);                                 // clean bank
    stuck_en[5] = 1; stuck_val[5] = 4'd0;
    run(0, 0, 0);                                 // reg 5 stuck at 0
    chk("stuck5_ea", err_addr[0], 5);
    chk("stuck5_cnt", mism[0], 1);
    no_faults(); wdis = 1;
    run(0, 0, 0);                                 // write enable disconnected
    chk("wdis_cnt", mism[0], 8);
    no_faults();
    run(0, 0, 0);                                 // restart from DONE clears error
    run(0, 1, 0);                                 // start held high
    run(0, 0, 1);                                 // start poke while busy
    run(1, 0, 0);                                 // READ_LAT=2, SEED=3 wrap pattern

    // Reset in the 4th WRITE cycle
    clr = 1; @(negedge clk); clr = 0;
    start[0] = 1; @(negedge clk); start[0] = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_we", reg_write[0], 1);
    rst = 1; #1;
    chk("mid_rst_we", reg_write[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_aw", addr_w[0], 0);
    chk("mid_rst_dw", dat_w[0], 0);
    @(negedge clk); rst = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", busy[0], 0);
    chk("post_rst_we", reg_write[0], 0);
    chk("post_rst_done", done[0], 0);

    // Randomised fault patterns on either instance
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 8; i++) begin
        stuck_en[i]  = ($urandom_range(0, 3) == 0);
        stuck_val[i] = 4'($urandom_range(0, 15));
      end
      wdis = ($urandom_range(0, 4) == 0);
      run(int'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bancoreg_sequencer.md
Name: bancoreg_sequencer

Overview:
- Initiator/tester for the 8x4 register bank (Bancoreg): drives the bank's write port (addrW, datW, RegWrite) and both read ports (addrRa, addrRb), then checks the returned read data.
- On start it writes all 8 registers with a descending pattern, reads them back two at a time, and reports pass/fail, first failing address and a mismatch count.
- Sits beside Bancoreg on the board; used for power-on self-test and as the bank's bench stimulus generator.

Parameters:
- ADDR_W, 3, bank address width; register count N = 2**ADDR_W.
- DATA_W, 4, bank data width.
- SEED, 15, pattern base; expected value of register i = (SEED - i) mod 2**DATA_W.
- READ_LAT, 1, cycles from address presentation to data valid at datOutRa/datOutRb (allowed range 0..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a test run; sampled in IDLE or DONE only.
- datOutRa  in  DATA_W  bank read port A data.
- datOutRb  in  DATA_W  bank read port B data.
- addrRa  out  ADDR_W  bank read address A.
- addrRb  out  ADDR_W  bank read address B.
- addrW  out  ADDR_W  bank write address.
- datW  out  DATA_W  bank write data.
- RegWrite  out  1  bank write enable.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start.
- error  out  1  sticky: at least one mismatch in the current run.
- err_addr  out  ADDR_W  address of the first mismatch.
- mism_cnt  out  ADDR_W+1  number of mismatching reads, 0..N.

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE. Assertion mid-run forces RegWrite=0 immediately (combinational with rst) and abandons the run. Nothing is retained.
- All outputs are registered.
- FSM states: IDLE, WRITE, RD_SET, RD_WAIT, RD_CHK, DONE.
- IDLE -> WRITE on start=1. On entry: busy=1, done=0, error=0, err_addr=0, mism_cnt=0, index i=0.
- WRITE: one register per cycle; addrW=i, datW=(SEED-i) mod 2**DATA_W, RegWrite=1.
  - Exactly N cycles, i=0..N-1, RegWrite high for exactly N consecutive cycles.
  - After i=N-1: RegWrite=0, go to RD_SET with pair index p=0.
- RD_SET: addrRa=p, addrRb=N-1-p, held stable until the pair is checked. Next state is RD_WAIT if READ_LAT>1, otherwise RD_CHK.
- RD_WAIT: counts READ_LAT-1 cycles, then goes to RD_CHK.
- RD_CHK: samples datOutRa and datOutRb (total pair time = 1+READ_LAT cycles; READ_LAT=0 samples in the RD_SET cycle itself, so each pair takes 1 cycle). Each port compared against its expected pattern value.
  - Per mismatching port: mism_cnt += 1 (both ports can add 1 in the same cycle, giving +2).
  - First mismatch of the run: error=1 and err_addr=that address. If both ports fail on the first failing pair, port A's address wins.
  - Later mismatches do not change err_addr.
  - If p < N/2-1: p+=1, go to RD_SET; else go to DONE.
- DONE: busy=0, done=1. Outputs error, err_addr and mism_cnt hold their values. start=1 restarts the run, same as from IDLE.
- start while busy=1 is ignored. start is a level; one run is launched per sampled assertion.
- Run length (start sample to done=1): N + (N/2)(1+max(READ_LAT,1)) + 1 cycles for READ_LAT>=1. Default parameters: 8 + 4*2 + 1 = 17 cycles.
- Write data wraps mod 2**DATA_W: with SEED=3 the pattern is 3,2,1,0,15,14,13,12.
- mism_cnt saturates at N; it cannot overflow since at most N reads occur per run.

Test Plan:
- Reset, then start pulse with a correct bank model: RegWrite high 8 cycles writing addr 0..7 with data 15,14,...,8. Read pairs (0,7),(1,6),(2,5),(3,4). done=1 at cycle 17, error=0, mism_cnt=0.
- Bank model with register 5 stuck at 0: error=1, err_addr=5, mism_cnt=1 (a single failing read, on port B of pair (2,5)).
- Bank model with write enable disconnected (all reads return 0): error=1, err_addr=0, mism_cnt=8.
- rst asserted during cycle 4 of WRITE: RegWrite drops to 0 in the same cycle, all outputs 0. After release, the FSM stays in IDLE until start.
- start held high through the run: only one run occurs until DONE. A restart from DONE clears error and mism_cnt. A start pulse while busy has no effect.
- READ_LAT=2, SEED=3: the bank model's data is delayed 2 cycles, expected pattern 3,2,1,0,15,14,13,12. Run passes in 8+4*3+1 = 21 cycles.
